pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage 16-bit processor (8-bit PC, 3-bit reg addresses).

---
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage 16-bit pipeline. Stalls one cycle on
//   a load-use hazard, squashes IF/ID and ID/EX on a taken jump, and drains the
//   pipe then halts when an end-of-program instruction reaches ID. It also
//   registers the EX-stage forwarding selects as the ID/EX register loads.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   id_rs1/id_rs2/id_use1/2   ID source addresses and read flags
//   id_eop                    ID instruction is end-of-program
//   ex_aD/ex_regwr/ex_load    EX destination, write enable, load flag
//   mem_aD/mem_regwr          MEM destination and write enable
//   jmp                       jump taken (resolved in EX)
//   pc_en/if_id_en            PC and IF/ID load enables
//   if_id_flush/id_ex_bubble  clear IF/ID, insert NOP into ID/EX
//   s1_c0/s1_c1/s2_c0/s2_c1   forwarding selects (c0 = EX/MEM, c1 = WB)
//   halted                    pipe drained, sticky until reset
//   stall_cnt                 saturating count of stall/drain/halt cycles
module pipe_hazard_ctrl #(
  parameter int AW        = 3,
  parameter int R0_ZERO   = 1,
  parameter int DRAIN_CYC = 3,
  parameter int SCW       = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  id_rs1,
  input  logic [AW-1:0]  id_rs2,
  input  logic           id_use1,
  input  logic           id_use2,
  input  logic           id_eop,
  input  logic [AW-1:0]  ex_aD,
  input  logic [1:0]     ex_regwr,
  input  logic           ex_load,
  input  logic [AW-1:0]  mem_aD,
  input  logic [1:0]     mem_regwr,
  input  logic           jmp,
  output logic           pc_en,
  output logic           if_id_en,
  output logic           if_id_flush,
  output logic           id_ex_bubble,
  output logic           s1_c0,
  output logic           s1_c1,
  output logic           s2_c0,
  output logic           s2_c1,
  output logic           halted,
  output logic [SCW-1:0] stall_cnt
);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_RUN, S_LDSTALL, S_FLUSH, S_DRAIN, S_HALT
  } state_t;

  state_t          state_q, state_d, cur;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]      fwd_q, fwd_d;     // {s1_c0, s1_c1, s2_c0, s2_c1}

  logic ex_wr, mem_wr, ld_haz, bubble;
  logic f1_c0, f1_c1, f2_c0, f2_c1;

  // Address match; register 0 never matches when it is hardwired.
  function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  assign ex_wr  = |ex_regwr;
  assign mem_wr = |mem_regwr;

  assign ld_haz = ex_load & ex_wr &
                  ((id_use1 & hit(id_rs1, ex_aD)) | (id_use2 & hit(id_rs2, ex_aD)));

  // Effective state for this cycle: from RUN the chosen action applies in the
  // same cycle, so the registered state only carries the follow-on cycles.
  always_comb begin
    cur = state_q;
    if (state_q == S_RUN) begin
      if (jmp)         cur = S_FLUSH;
      else if (ld_haz) cur = S_LDSTALL;
      else if (id_eop) cur = S_DRAIN;
    end
  end

  always_comb begin
    state_d = S_RUN;
    drain_d = drain_q;
    case (cur)
      S_RUN:     state_d = S_RUN;
      S_LDSTALL: state_d = jmp ? S_FLUSH : S_RUN;
      S_FLUSH:   state_d = S_RUN;
      S_DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          state_d = S_HALT;
          drain_d = '0;
        end else begin
          state_d = S_DRAIN;
          drain_d = drain_q + DCW'(1);
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    bubble      = 1'b0;
    case (cur)
      S_LDSTALL: begin pc_en = 1'b0; if_id_en = 1'b0; bubble = 1'b1; end
      S_FLUSH:   begin if_id_flush = 1'b1; bubble = 1'b1; end
      S_DRAIN,
      S_HALT:    begin pc_en = 1'b0; if_id_en = 1'b0; bubble = 1'b1; end
      default:   ;
    endcase
    // Hold the pipe in NOPs for as long as reset is asserted.
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      bubble      = 1'b1;
    end
  end

  assign id_ex_bubble = bubble;

  // EX/MEM result wins over WB data, so c1 is masked by c0.
  assign f1_c0 = id_use1 & ex_wr & ~ex_load & hit(id_rs1, ex_aD);
  assign f1_c1 = ~f1_c0 & id_use1 & mem_wr & hit(id_rs1, mem_aD);
  assign f2_c0 = id_use2 & ex_wr & ~ex_load & hit(id_rs2, ex_aD);
  assign f2_c1 = ~f2_c0 & id_use2 & mem_wr & hit(id_rs2, mem_aD);

  assign fwd_d = bubble ? 4'b0000 : {f1_c0, f1_c1, f2_c0, f2_c1};

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((cur == S_LDSTALL || cur == S_DRAIN || cur == S_HALT) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + SCW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      fwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_q       <= fwd_d;
    end
  end

  assign {s1_c0, s1_c1, s2_c0, s2_c1} = fwd_q;
  assign halted    = (state_q == S_HALT);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs1, id_rs2, ex_aD, mem_aD;
  logic        id_use1, id_use2, id_eop, ex_load, jmp;
  logic [1:0]  ex_regwr, mem_regwr;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic        s1_c0, s1_c1, s2_c0, s2_c1, halted;
  logic [15:0] stall_cnt;
  logic [3:0]  ctrl, sel;

  int total  = 0;
  int passed = 0;
  logic [3:0] sb[$];   // expected forwarding selects, one per ID/EX load

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_eop(id_eop), .ex_aD(ex_aD), .ex_regwr(ex_regwr), .ex_load(ex_load),
    .mem_aD(mem_aD), .mem_regwr(mem_regwr), .jmp(jmp),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .s1_c0(s1_c0), .s1_c1(s1_c1),
    .s2_c0(s2_c0), .s2_c1(s2_c1), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_bubble};
  assign sel  = {s1_c0, s1_c1, s2_c0, s2_c1};

  task automatic drive(input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic u1, input logic u2, input logic eop,
                       input logic [2:0] eaD, input logic [1:0] erw, input logic ld,
                       input logic [2:0] maD, input logic [1:0] mrw, input logic j);
    id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2; id_eop = eop;
    ex_aD = eaD; ex_regwr = erw; ex_load = ld;
    mem_aD = maD; mem_regwr = mrw; jmp = j;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #2;
    total++; if (ctrl !== 4'b0011) $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 4'b0011); else passed++;
    total++; if (sel !== 4'b0000) $display("FAIL reset_sel got=%b exp=%b", sel, 4'b0000); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(posedge clk); #1;
    total++; if (ctrl !== 4'b0011) $display("FAIL reset_hold_ctrl got=%b exp=%b", ctrl, 4'b0011); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL reset_run_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
  endtask

  task automatic test_forward();
    logic [3:0] e;
    do_reset();
    // ADD r2,r1,r1 directly behind ADD r1: both operands from EX/MEM
    drive(1, 1, 1, 1, 0, 1, 2'b01, 0, 0, 0, 0); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL fwd_nostall got=%b exp=%b", ctrl, 4'b1100); else passed++;
    sb.push_back(4'b1010);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL fwd_ex got=%b exp=%b", sel, e); else passed++;
    // one independent instruction between: both operands from WB
    @(negedge clk); drive(1, 1, 1, 1, 0, 5, 2'b01, 0, 1, 2'b10, 0); sb.push_back(4'b0101);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL fwd_wb got=%b exp=%b", sel, e); else passed++;
    // EX and MEM both write r2: EX/MEM wins for rs1, rs2 unmatched
    @(negedge clk); drive(2, 3, 1, 1, 0, 2, 2'b01, 0, 2, 2'b01, 0); sb.push_back(4'b1000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL fwd_prio got=%b exp=%b", sel, e); else passed++;
    // EX does not write: falls through to WB
    @(negedge clk); drive(4, 4, 1, 1, 0, 4, 2'b00, 0, 4, 2'b11, 0); sb.push_back(4'b0101);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL fwd_nowr got=%b exp=%b", sel, e); else passed++;
    // operands not read: nothing forwarded
    @(negedge clk); drive(1, 1, 0, 0, 0, 1, 2'b01, 0, 1, 2'b01, 0); sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL fwd_nouse got=%b exp=%b", sel, e); else passed++;
  endtask

  task automatic test_ldstall();
    logic [3:0] e;
    do_reset();
    // LW r3 in EX, ID reads r3
    drive(3, 4, 1, 1, 0, 3, 2'b01, 1, 0, 0, 0); #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL ld_stall_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL ld_bubble_sel got=%b exp=%b", sel, e); else passed++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL ld_stall_cnt got=%0d exp=1", stall_cnt); else passed++;
    // load now in MEM behind a bubble in EX
    @(negedge clk); drive(3, 4, 1, 1, 0, 0, 2'b00, 0, 3, 2'b01, 0); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL ld_resume_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    sb.push_back(4'b0100);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL ld_fwd_wb got=%b exp=%b", sel, e); else passed++;
    total++; if (stall_cnt !== 16'd1) $display("FAIL ld_stall_cnt2 got=%0d exp=1", stall_cnt); else passed++;
    // matching rs2 that is not read: no hazard
    @(negedge clk); drive(5, 3, 1, 0, 0, 3, 2'b01, 1, 0, 0, 0); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL ld_nouse_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    @(posedge clk);
  endtask

  task automatic test_jmp_priority();
    logic [3:0] e;
    do_reset();
    drive(3, 3, 1, 1, 1, 3, 2'b01, 1, 0, 0, 1); #1;
    total++; if (ctrl !== 4'b1111) $display("FAIL jmp_ctrl got=%b exp=%b", ctrl, 4'b1111); else passed++;
    sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL jmp_sel got=%b exp=%b", sel, e); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL jmp_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL jmp_after_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    @(posedge clk); #1;
    total++; if (halted !== 1'b0) $display("FAIL jmp_halted got=%b exp=0", halted); else passed++;
  endtask

  task automatic test_eop();
    logic [3:0] e;
    do_reset();
    // eop with a forwardable operand: bubble still zeroes the selects
    drive(1, 0, 1, 0, 1, 1, 2'b01, 0, 0, 0, 0); #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL eop_d0_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL eop_sel got=%b exp=%b", sel, e); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL eop_d0_halted got=%b exp=0", halted); else passed++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;   // jmp ignored while draining
    total++; if (ctrl !== 4'b0001) $display("FAIL eop_d1_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    @(posedge clk); #1;
    total++; if (halted !== 1'b0) $display("FAIL eop_d1_halted got=%b exp=0", halted); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL eop_d2_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    @(posedge clk); #1;
    total++; if (halted !== 1'b1) $display("FAIL eop_halted got=%b exp=1", halted); else passed++;
    total++; if (stall_cnt !== 16'd3) $display("FAIL eop_stall_cnt got=%0d exp=3", stall_cnt); else passed++;
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL halt_jmp_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    @(posedge clk); #1;
    total++; if (halted !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", halted); else passed++;
    total++; if (stall_cnt !== 16'd4) $display("FAIL halt_stall_cnt got=%0d exp=4", stall_cnt); else passed++;
  endtask

  task automatic test_r0();
    logic [3:0] e;
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 2'b01, 1, 0, 2'b01, 0); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL r0_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL r0_sel_ld got=%b exp=%b", sel, e); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL r0_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(negedge clk); drive(0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 2'b01, 0); sb.push_back(4'b0000);
    @(posedge clk); #1; e = sb.pop_front();
    total++; if (sel !== e) $display("FAIL r0_sel_alu got=%b exp=%b", sel, e); else passed++;
  endtask

  task automatic test_rst_drain();
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++; if (ctrl !== 4'b0001) $display("FAIL rd_drain_ctrl got=%b exp=%b", ctrl, 4'b0001); else passed++;
    rst = 1'b1; #1;
    total++; if (ctrl !== 4'b0011) $display("FAIL rd_async_ctrl got=%b exp=%b", ctrl, 4'b0011); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL rd_async_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(negedge clk); rst = 1'b0; #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL rd_release_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
    @(posedge clk); #1;
    total++; if (halted !== 1'b0) $display("FAIL rd_halted got=%b exp=0", halted); else passed++;
    total++; if (stall_cnt !== 16'd0) $display("FAIL rd_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(negedge clk); #1;
    total++; if (ctrl !== 4'b1100) $display("FAIL rd_run_ctrl got=%b exp=%b", ctrl, 4'b1100); else passed++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_ldstall();
    test_jmp_priority();
    test_eop();
    test_r0();
    test_rst_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
